// File: rtl/char_normalizer_pkg.sv
// Shared definitions for the character normalizer: ASCII constants, FSM states
// and the byte classifier.
package char_normalizer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WCNT_W = 16;

  localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_NUL   = 8'h00;
  localparam logic [BYTE_W-1:0] ASCII_TAB   = 8'h09;
  localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_WORD  = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_LETTER = 3'd0,
    CLS_PRINT  = 3'd1,
    CLS_SPACE  = 3'd2,
    CLS_NUL    = 3'd3,
    CLS_JUNK   = 3'd4
  } char_class_e;

  function automatic char_class_e classify(input logic [BYTE_W-1:0] b);
    char_class_e c;
    if (b >= 8'h41 && b <= 8'h5A) begin
      c = CLS_LETTER;
    end else if (b >= 8'h21 && b <= 8'h7E) begin
      c = CLS_PRINT;
    end else if (b == ASCII_SPACE || b == ASCII_TAB || b == ASCII_LF || b == ASCII_CR) begin
      c = CLS_SPACE;
    end else if (b == ASCII_NUL) begin
      c = CLS_NUL;
    end else begin
      c = CLS_JUNK;
    end
    return c;
  endfunction

  // Only valid for 'A'-'Z'; upper and lower case differ in bit 5.
  function automatic logic [BYTE_W-1:0] to_lower(input logic [BYTE_W-1:0] b);
    return b | 8'h20;
  endfunction

endpackage

// File: rtl/char_normalizer_sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers and registered
// full/empty flags; head data is visible the edge after the push.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == CNT_W'(0));
    end
  end

  // Storage needs no reset: reads are masked by the empty flag downstream.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/char_normalizer.sv
// Lowercases letters, collapses whitespace, drops junk and flushes on NUL,
// then buffers the normalized stream in a small FIFO for the checker.
module char_normalizer
  import char_normalizer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WCNT_W-1:0] word_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e            state_q;
  state_e            state_d;
  logic [WCNT_W-1:0] word_count_q;
  logic [WCNT_W-1:0] word_count_d;
  char_class_e       cls;
  logic              accept;
  logic              push_c;
  logic [BYTE_W-1:0] push_data_c;
  logic              word_start_c;
  logic              pop;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign cls    = classify(in);
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Next state, push request and word-start detection for the accepted byte.
  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    push_data_c  = ASCII_SPACE;
    word_start_c = 1'b0;
    if (accept) begin
      case (cls)
        CLS_LETTER: begin
          push_c       = 1'b1;
          push_data_c  = to_lower(in);
          word_start_c = (state_q != ST_WORD);
          state_d      = ST_WORD;
        end
        CLS_PRINT: begin
          push_c       = 1'b1;
          push_data_c  = in;
          word_start_c = (state_q != ST_WORD);
          state_d      = ST_WORD;
        end
        CLS_SPACE: begin
          if (state_q == ST_WORD) begin
            push_c  = 1'b1;
            state_d = ST_GAP;
          end
        end
        CLS_NUL: begin
          push_c  = (state_q == ST_WORD);
          state_d = ST_START;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    word_count_d = word_count_q;
    if (word_start_c && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_START;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .data_i  (push_data_c),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign out_valid  = (fifo_count != CNT_W'(0));
  assign out        = fifo_empty ? ASCII_NUL : fifo_head;
  assign word_count = word_count_q;

endmodule
